// File: rtl/ip_iobus_master.sv
// MSX-50BUS I/O initiator: turns a req/ack handshake into a Z80-style I/O read
// or write cycle with programmable setup, strobe and hold lengths.
//
// state  | meaning
// IDLE   | waiting for req; address/d keep their last values
// SETUP  | address/data valid, strobes high
// STROBE | iorq_n plus rd_n or wr_n low; read data captured
// HOLD   | strobes high, address/data held; read data still captured
// ACK    | one-cycle ack pulse, busy still high
module ip_iobus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_wr,
    input  logic [7:0] req_address,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       no_response,
    output logic       iorq_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] address,
    output logic [7:0] d,
    input  logic [7:0] q,
    input  logic       q_en
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] ACK    = 3'd4;

    // A zero SETUP_CYCLES wraps this load value, but SETUP is then never entered.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic       is_wr;
    logic [7:0] capture;
    logic       seen;
    logic [7:0] capture_next;
    logic       seen_next;

    // The final HOLD cycle's response must reach rdata on the same edge as ack.
    always_comb begin
        capture_next = capture | (q_en ? q : 8'h00);
        seen_next    = seen | q_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            is_wr       <= 1'b0;
            capture     <= 8'h00;
            seen        <= 1'b0;
            busy        <= 1'b0;
            ack         <= 1'b0;
            rdata       <= 8'h00;
            no_response <= 1'b0;
            iorq_n      <= 1'b1;
            rd_n        <= 1'b1;
            wr_n        <= 1'b1;
            address     <= 8'h00;
            d           <= 8'h00;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        is_wr   <= req_wr;
                        address <= req_address;
                        busy    <= 1'b1;
                        if (req_wr) begin
                            d <= req_wdata;
                        end else begin
                            capture <= 8'h00;
                            seen    <= 1'b0;
                        end
                        if (SETUP_CYCLES == 0) begin
                            state  <= STROBE;
                            cnt    <= STROBE_LOAD;
                            iorq_n <= 1'b0;
                            rd_n   <= req_wr;
                            wr_n   <= ~req_wr;
                        end else begin
                            state <= SETUP;
                            cnt   <= SETUP_LOAD;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state  <= STROBE;
                        cnt    <= STROBE_LOAD;
                        iorq_n <= 1'b0;
                        rd_n   <= is_wr;
                        wr_n   <= ~is_wr;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    capture <= capture_next;
                    seen    <= seen_next;
                    if (cnt == 4'd0) begin
                        state  <= HOLD;
                        cnt    <= HOLD_LOAD;
                        iorq_n <= 1'b1;
                        rd_n   <= 1'b1;
                        wr_n   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    capture <= capture_next;
                    seen    <= seen_next;
                    if (cnt == 4'd0) begin
                        state <= ACK;
                        ack   <= 1'b1;
                        if (is_wr) begin
                            no_response <= 1'b0;
                        end else begin
                            rdata       <= seen_next ? capture_next : 8'hFF;
                            no_response <= ~seen_next;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_iobus_master.sv
// Bench for ip_iobus_master: directed and random I/O cycles against a
// GPIO-style responder, checked cycle by cycle against the timing rules.
module tb_ip_iobus_master;

    localparam int S = 1;
    localparam int P = 4;
    localparam int H = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       req, req_wr;
    logic [7:0] req_address, req_wdata;
    logic       busy, ack, no_response, iorq_n, rd_n, wr_n, q_en;
    logic [7:0] rdata, address, d, q;

    logic       req2;
    logic       busy2, ack2, no_response2, iorq_n2, rd_n2, wr_n2, q_en2;
    logic [7:0] rdata2, address2, d2, q2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ip_iobus_master dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr),
        .req_address(req_address), .req_wdata(req_wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .no_response(no_response),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .address(address), .d(d),
        .q(q), .q_en(q_en)
    );

    ip_iobus_master #(.SETUP_CYCLES(0), .STROBE_CYCLES(2), .HOLD_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .req_wr(1'b0),
        .req_address(8'h81), .req_wdata(8'h00),
        .busy(busy2), .ack(ack2), .rdata(rdata2), .no_response(no_response2),
        .iorq_n(iorq_n2), .rd_n(rd_n2), .wr_n(wr_n2), .address(address2), .d(d2),
        .q(q2), .q_en(q_en2)
    );

    // Responder A at 8'h10: latches d when wr_n rises with the address still held,
    // answers reads with a one-cycle registered q_en.
    logic [7:0] gpio_reg = 8'h00;
    logic       wr_q = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] qa = 8'h00;
    logic       enb;

    always @(posedge clk) begin
        wr_q <= wr_n;
        if (!wr_q && wr_n && address == 8'h10) gpio_reg <= d;
        ena <= !iorq_n && !rd_n && address == 8'h10;
        qa  <= (!iorq_n && !rd_n && address == 8'h10) ? gpio_reg : 8'h00;
    end

    // Responder B at 8'h20: combinational constant 8'hC3.
    assign enb   = !iorq_n && !rd_n && address == 8'h20;
    assign q     = qa | (enb ? 8'hC3 : 8'h00);
    assign q_en  = ena | enb;
    assign q_en2 = !iorq_n2 && !rd_n2 && address2 == 8'h81;
    assign q2    = q_en2 ? 8'h81 : 8'h00;

    logic [7:0] gpio_model = 8'h00;
    logic [7:0] last_rdata = 8'h00;
    logic [7:0] last_d     = 8'h00;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves at the negedge of the
    // single IDLE cycle that follows ack.
    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                           input bit keep, input bit pulse);
        logic [7:0] exp_rd;
        logic       exp_nr;
        req_wr = wr; req_address = a; req_wdata = wd; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) req = 1'b0;
        if (wr) begin
            last_d = wd;
            exp_rd = last_rdata; exp_nr = 1'b0;
        end else if (a == 8'h10) begin
            exp_rd = gpio_model; exp_nr = 1'b0;
        end else if (a == 8'h20) begin
            exp_rd = 8'hC3; exp_nr = 1'b0;
        end else begin
            exp_rd = 8'hFF; exp_nr = 1'b1;
        end
        for (int k = 1; k <= S + P + H + 2; k++) begin
            logic stb;
            stb = (k >= S + 1) && (k <= S + P);
            chk1("iorq_n", iorq_n, !stb);
            chk1("rd_n", rd_n, !(stb && !wr));
            chk1("wr_n", wr_n, !(stb && wr));
            chk1("busy", busy, k <= S + P + H + 1);
            chk1("ack", ack, k == S + P + H + 1);
            chk8("address", address, a);
            chk8("d", d, last_d);
            if (k >= S + P + H + 1) begin
                chk8("rdata", rdata, exp_rd);
                chk1("no_response", no_response, exp_nr);
            end
            if (pulse && k == 2) begin
                req = 1'b1; req_wr = !wr; req_address = 8'h20; req_wdata = 8'h5A;
            end
            if (pulse && k == 3) req = 1'b0;
            if (k < S + P + H + 2) @(negedge clk);
        end
        last_rdata = exp_rd;
        if (wr && a == 8'h10) gpio_model = wd;
        chk8("gpio_reg", gpio_reg, gpio_model);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = 1'b0; req_wr = 1'b0; req_address = 8'h00; req_wdata = 8'h00;
        req2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk1("rst_iorq_n", iorq_n, 1'b1);
        chk1("rst_rd_n", rd_n, 1'b1);
        chk1("rst_wr_n", wr_n, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ack", ack, 1'b0);
        chk8("rst_address", address, 8'h00);
        chk8("rst_d", d, 8'h00);
        chk8("rst_rdata", rdata, 8'h00);
        chk1("rst_no_response", no_response, 1'b0);
        chk1("rst_busy2", busy2, 1'b0);

        run_txn(1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
        chk8("gpio_a5", gpio_reg, 8'hA5);
        run_txn(1'b1, 8'h10, 8'h3C, 1'b0, 1'b0);
        run_txn(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        run_txn(1'b0, 8'h55, 8'h00, 1'b0, 1'b0);
        run_txn(1'b1, 8'h20, 8'h77, 1'b0, 1'b0);

        // req held across a write then a read: exactly one idle cycle between.
        run_txn(1'b1, 8'h10, 8'h96, 1'b1, 1'b0);
        run_txn(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        run_txn(1'b0, 8'h55, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_ack", ack, 1'b0);
        end

        // Reset during the STROBE of a write.
        req_wr = 1'b1; req_address = 8'h10; req_wdata = 8'h11; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk1("pre_rst_wr_n", wr_n, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk1("mid_rst_iorq_n", iorq_n, 1'b1);
        chk1("mid_rst_wr_n", wr_n, 1'b1);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ack", ack, 1'b0);
        chk8("mid_rst_address", address, 8'h00);
        chk8("mid_rst_d", d, 8'h00);
        chk8("mid_rst_rdata", rdata, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk1("post_rst_ack", ack, 1'b0);
        end
        chk8("post_rst_gpio", gpio_reg, gpio_model);
        last_rdata = 8'h00;
        last_d     = 8'h00;

        for (int i = 0; i < 24; i++) begin
            logic       wr;
            logic [7:0] a;
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 8'h10;
                1: a = 8'h20;
                2: a = 8'h55;
                default: a = 8'($urandom);
            endcase
            run_txn(wr, a, 8'($urandom), 1'($urandom_range(0, 1)) & wr, 1'b0);
        end
        req = 1'b0;
        repeat (2) @(negedge clk);

        // Minimal timing instance: strobe in cycles 1..2, ack in cycle 4.
        req2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk1("p2_iorq_n", iorq_n2, !(k <= 2));
            chk1("p2_rd_n", rd_n2, !(k <= 2));
            chk1("p2_wr_n", wr_n2, 1'b1);
            chk1("p2_busy", busy2, k <= 4);
            chk1("p2_ack", ack2, k == 4);
            if (k == 4) begin
                chk8("p2_rdata", rdata2, 8'h81);
                chk1("p2_no_response", no_response2, 1'b0);
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
